// File: rtl/ec_arb_pkg.sv
// ec_arb_pkg: shared arbiter state type and round-robin pointer helper
package ec_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester bundle plus downstream channel of the arbiter
interface mux_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS_NUM = 3
);
  localparam int SELECT_WIDTH = $clog2(INPUTS_NUM);
  logic [INPUTS_NUM-1:0] req_valid;
  logic [INPUTS_NUM-1:0] req_last;
  logic [DATA_WIDTH-1:0] req_data [INPUTS_NUM];
  logic [INPUTS_NUM-1:0] req_ready;
  logic out_valid;
  logic out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_ready;
  logic [SELECT_WIDTH-1:0] sel;
  logic busy;
  modport master (
    output req_valid, req_last, req_data, out_ready,
    input req_ready, out_valid, out_last, out_data, sel, busy
  );
  modport slave (
    input req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_last, out_data, sel, busy
  );
endinterface

// File: rtl/gen_mux.sv
// gen_mux: generic N-to-1 data word multiplexer, out-of-range select yields zero
module gen_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS_NUM = 3
) (
  input  logic [DATA_WIDTH-1:0]         inputs_arr [INPUTS_NUM],
  input  logic [$clog2(INPUTS_NUM)-1:0] sel,
  output logic [DATA_WIDTH-1:0]         out
);
  localparam int SELECT_WIDTH = $clog2(INPUTS_NUM);
  // one-hot compare per input keeps the index safely bounded
  always_comb begin
    out = '0;
    for (int i = 0; i < INPUTS_NUM; i++)
      if (sel == SELECT_WIDTH'(i)) out = inputs_arr[i];
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: packet-aware round-robin arbiter sharing one channel among requesters
module mux_rr_arbiter
  import ec_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS_NUM = 3,
  parameter int MAX_BURST  = 16
) (
  input logic clk,
  input logic rst_n,
  mux_rr_arbiter_if.slave bus
);
  localparam int SELECT_WIDTH = $clog2(INPUTS_NUM);
  localparam int CNT_WIDTH = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  state_t state;
  logic [SELECT_WIDTH-1:0] sel;
  logic [SELECT_WIDTH-1:0] prio_ptr;
  logic [SELECT_WIDTH-1:0] pick;
  logic found;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic granted;
  logic burst_end;
  logic beat;
  // first valid requester at or after prio_ptr, wrapping around
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = 0; i < INPUTS_NUM; i++) begin
      int idx;
      idx = int'(prio_ptr) + i;
      idx = (idx >= INPUTS_NUM) ? idx - INPUTS_NUM : idx;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick = SELECT_WIDTH'(idx);
      end
    end
  end
  assign granted   = (state == GRANT);
  assign burst_end = (MAX_BURST != 0) && (int'(beat_cnt) == MAX_BURST - 1);
  assign beat      = bus.out_valid && bus.out_ready;
  assign bus.out_valid = granted && bus.req_valid[sel];
  assign bus.out_last  = granted && (bus.req_last[sel] || burst_end);
  assign bus.req_ready = granted ? (INPUTS_NUM'(bus.out_ready) << sel) : '0;
  assign bus.sel  = sel;
  assign bus.busy = granted;
  gen_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .INPUTS_NUM(INPUTS_NUM)
  ) u_mux (
    .inputs_arr(bus.req_data),
    .sel(sel),
    .out(bus.out_data)
  );
  // arbitrate in IDLE, hold the grant until a last or forced-release beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      prio_ptr <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= GRANT;
        sel <= pick;
        beat_cnt <= '0;
      end
    end else if (beat) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      if (bus.out_last) begin
        state <= IDLE;
        prio_ptr <= SELECT_WIDTH'(rr_next(int'(sel), INPUTS_NUM));
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: randomized check of the arbiter against a grant-level reference model
module tb_mux_rr_arbiter;
  localparam int DW = 8;
  localparam int N  = 3;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mux_rr_arbiter_if #(.DATA_WIDTH(DW), .INPUTS_NUM(N)) bus ();
  mux_rr_arbiter #(
    .DATA_WIDTH(DW),
    .INPUTS_NUM(N),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  int checks = 0;
  int errors = 0;
  int seq [N];
  int rem [N];
  int mode = 0;
  int cyc = 0;
  int owner = -1;
  int ptr = 0;
  int cnt = 0;
  int beats = 0;
  int forced = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int new_len();
    return (mode == 0) ? 1 : int'($urandom_range(1, 10));
  endfunction
  function automatic logic [DW-1:0] word(input int i);
    return DW'(i * 64 + seq[i] % 64);
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (mode == 0) ? 1'b1 :
                         (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      bus.req_last[i] = (rem[i] == 1);
      bus.req_data[i] = word(i);
    end
    bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ((cyc % 8) >= 5);
  endtask
  task automatic step();
    logic ev, el, beat;
    @(negedge clk);
    rst_n = 1'b1;
    drive();
    #1;
    ev = (owner >= 0) && bus.req_valid[owner];
    el = (owner >= 0) && (bus.req_last[owner] || cnt == MB - 1);
    check("busy", 32'(bus.busy), 32'(owner >= 0));
    if (owner >= 0) check("sel", 32'(bus.sel), 32'(owner));
    check("out_valid", 32'(bus.out_valid), 32'(ev));
    check("out_last", 32'(bus.out_last), 32'(el));
    check("req_ready", 32'(bus.req_ready),
          (owner >= 0 && bus.out_ready) ? 32'(1) << owner : 32'(0));
    if (ev) check("out_data", 32'(bus.out_data), 32'(word(owner)));
    beat = ev && bus.out_ready;
    @(posedge clk);
    if (owner < 0) begin
      for (int k = 0; k < N; k++)
        if (owner < 0 && bus.req_valid[(ptr + k) % N]) begin
          owner = (ptr + k) % N;
          cnt = 0;
        end
    end else if (beat) begin
      beats++;
      cnt++;
      seq[owner]++;
      rem[owner]--;
      if (rem[owner] == 0) rem[owner] = new_len();
      if (el) begin
        if (!bus.req_last[owner]) forced++;
        ptr = (owner + 1) % N;
        owner = -1;
      end
    end
    cyc++;
  endtask
  initial begin
    bit hit;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      rem[i] = 1;
    end
    bus.req_valid = '1;
    bus.req_last = '1;
    for (int i = 0; i < N; i++) bus.req_data[i] = word(i);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("rst_sel", 32'(bus.sel), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_last", 32'(bus.out_last), 0);
    end
    mode = 0;
    repeat (30) step();
    mode = 1;
    repeat (150) step();
    mode = 2;
    repeat (150) step();
    mode = 1;
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      step();
      hit = (owner >= 0 && cnt == 2);
    end
    check("reset_window_found", 32'(hit), 1);
    if (hit) begin
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 0);
      check("arst_out_last", 32'(bus.out_last), 0);
      check("arst_req_ready", 32'(bus.req_ready), 0);
      check("arst_busy", 32'(bus.busy), 0);
      check("arst_sel", 32'(bus.sel), 0);
      owner = -1;
      ptr = 0;
      cnt = 0;
    end
    repeat (80) step();
    check("beats_seen", 32'(beats > 50), 1);
    check("forced_release_seen", 32'(forced > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
